// File: rtl/eth_frame_tx.sv
// Purpose: byte-serial Ethernet frame transmitter: 14 header bytes, fixed-length payload, zero pad to minimum length.
// Latency: first header byte is valid 1 cycle after s_tvalid is seen in IDLE; payload bytes pass through combinationally.
// Backpressure: m_tready stalls header/pad in place and is forwarded to s_tready during payload; s_tvalid gaps stall the output.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   header_in                     ethernet_header struct, latched when a frame starts
//   s_tdata/s_tvalid/s_tready     payload byte stream in
//   m_tdata/m_tvalid/m_tready     frame byte stream out, m_tlast marks the final byte
//   busy                          high whenever a frame is in progress
//   frame_count                   completed frames, wraps at 16 bits

package eth_pkg;
    // Packed so that index 0 of each field is the most significant byte,
    // which is also the first byte on the wire.
    typedef struct packed {
        logic [0:5][7:0] mac_destination;
        logic [0:5][7:0] mac_source;
        logic [0:1][7:0] eth_type_length;
    } ethernet_header;
endpackage

module eth_frame_tx
    import eth_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 128,
    parameter int MIN_PAYLOAD   = 46
) (
    input  logic           clk,
    input  logic           rst,
    input  ethernet_header header_in,
    input  logic [7:0]     s_tdata,
    input  logic           s_tvalid,
    output logic           s_tready,
    output logic [7:0]     m_tdata,
    output logic           m_tvalid,
    input  logic           m_tready,
    output logic           m_tlast,
    output logic           busy,
    output logic [15:0]    frame_count
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PAD} state_t;

    localparam logic        NEED_PAD = (PAYLOAD_BYTES < MIN_PAYLOAD);
    localparam logic [15:0] LAST_PAY = 16'(PAYLOAD_BYTES - 1);
    localparam logic [15:0] LAST_PAD = 16'(MIN_PAYLOAD - 1);

    state_t           state;
    ethernet_header   hdr_q;
    logic [0:13][7:0] hdr_bytes;
    logic [3:0]       idx;
    logic [15:0]      pay_cnt;
    logic             xfer;

    // Flat byte view of the latched header in wire order.
    assign hdr_bytes = hdr_q;
    assign xfer      = m_tvalid && m_tready;
    assign busy      = (state != IDLE);

    // Outputs decode from registered state; only the payload phase is a
    // combinational pass-through of the upstream handshake.
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = 8'h00;
        m_tlast  = 1'b0;
        s_tready = 1'b0;
        case (state)
            HEADER: begin
                m_tvalid = 1'b1;
                m_tdata  = hdr_bytes[idx];
            end
            PAYLOAD: begin
                m_tvalid = s_tvalid;
                m_tdata  = s_tdata;
                s_tready = m_tready;
                m_tlast  = !NEED_PAD && (pay_cnt == LAST_PAY);
            end
            PAD: begin
                m_tvalid = 1'b1;
                m_tlast  = (pay_cnt == LAST_PAD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hdr_q       <= '0;
            idx         <= '0;
            pay_cnt     <= '0;
            frame_count <= '0;
        end else begin
            if (xfer && m_tlast) begin
                frame_count <= frame_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    // The waiting payload byte is not consumed here; it is
                    // forwarded once the header has gone out.
                    if (s_tvalid) begin
                        hdr_q   <= header_in;
                        idx     <= '0;
                        pay_cnt <= '0;
                        state   <= HEADER;
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        if (idx == 4'd13) begin
                            idx   <= '0;
                            state <= PAYLOAD;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        pay_cnt <= pay_cnt + 16'd1;
                        if (pay_cnt == LAST_PAY) begin
                            state <= NEED_PAD ? PAD : IDLE;
                        end
                    end
                end
                PAD: begin
                    // Counter keeps running from the payload count so the
                    // pad ends exactly at the minimum payload length.
                    if (xfer) begin
                        pay_cnt <= pay_cnt + 16'd1;
                        if (pay_cnt == LAST_PAD) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
module tb_eth_frame_tx;
    import eth_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    ethernet_header a_hdr, b_hdr;
    logic [7:0]     a_s_tdata, b_s_tdata, a_m_tdata, b_m_tdata;
    logic           a_s_tvalid, b_s_tvalid, a_s_tready, b_s_tready;
    logic           a_m_tvalid, b_m_tvalid, a_m_tready, b_m_tready;
    logic           a_m_tlast, b_m_tlast, a_busy, b_busy;
    logic [15:0]    a_fc, b_fc;

    // Default-length instance and a short-payload instance that pads.
    eth_frame_tx #(.PAYLOAD_BYTES(128), .MIN_PAYLOAD(46)) dut_a (
        .clk(clk), .rst(rst), .header_in(a_hdr),
        .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready),
        .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(a_m_tready),
        .m_tlast(a_m_tlast), .busy(a_busy), .frame_count(a_fc)
    );

    eth_frame_tx #(.PAYLOAD_BYTES(10), .MIN_PAYLOAD(46)) dut_b (
        .clk(clk), .rst(rst), .header_in(b_hdr),
        .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
        .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
        .m_tlast(b_m_tlast), .busy(b_busy), .frame_count(b_fc)
    );

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       pad;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;

    int tests = 0;
    int fails = 0;
    int rdy_mode = 0;

    logic [7:0] hb_def [14];
    logic [7:0] hb_new [14];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Scoreboard producer: header bytes, payload first+i, zero pad, tlast on final byte.
    task automatic expect_frame(input int which, input logic [7:0] hb [14],
                                input logic [7:0] first, input int n, input int minp);
        exp_t e;
        int total;
        total = (n < minp) ? minp : n;
        for (int i = 0; i < 14; i++) begin
            e.d = hb[i]; e.last = 1'b0; e.pad = 1'b0;
            if (which == 0) exp_a.push_back(e); else exp_b.push_back(e);
        end
        for (int i = 0; i < total; i++) begin
            e.d    = (i < n) ? first + 8'(i) : 8'h00;
            e.pad  = (i >= n);
            e.last = (i == total - 1);
            if (which == 0) exp_a.push_back(e); else exp_b.push_back(e);
        end
    endtask

    task automatic send_byte(input int which, input logic [7:0] d);
        int n;
        n = 0;
        if (which == 0) begin a_s_tdata = d; a_s_tvalid = 1'b1; end
        else            begin b_s_tdata = d; b_s_tvalid = 1'b1; end
        forever begin
            @(negedge clk);
            if ((which == 0) ? (a_s_tready === 1'b1) : (b_s_tready === 1'b1)) break;
            n++;
            if (n > 500) begin timeout_fail("send_byte"); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_payload(input int which, input logic [7:0] first, input int n,
                                input int gap_at, input bit hold);
        for (int i = 0; i < n; i++) begin
            send_byte(which, first + 8'(i));
            if (i == gap_at) begin
                if (which == 0) a_s_tvalid = 1'b0; else b_s_tvalid = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
            end
        end
        if (!hold) begin
            if (which == 0) a_s_tvalid = 1'b0; else b_s_tvalid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int which);
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (((which == 0) ? exp_a.size() : exp_b.size()) == 0) break;
            n++;
            if (n > 2000) begin timeout_fail("drain"); break; end
        end
    endtask

    // m_tready driver for instance A: steady high or toggling each cycle.
    initial begin
        a_m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 1) a_m_tready = ~a_m_tready;
            else               a_m_tready = 1'b1;
        end
    end

    // Monitor A: pops on every transfer, checks hold-during-stall and inter-frame gap.
    logic       a_prev_stall = 1'b0, a_prev_l = 1'b0, a_seen_last = 1'b0, a_gap_en = 1'b0;
    logic [7:0] a_prev_d = 8'h00;
    int         a_gap = 0;

    always @(negedge clk) begin
        if (rst) begin
            a_prev_stall = 1'b0; a_seen_last = 1'b0; a_gap = 0;
        end else begin
            if (a_prev_stall) begin
                check("a_hold_valid", 32'(a_m_tvalid), 1);
                check("a_hold_data", 32'(a_m_tdata), 32'(a_prev_d));
                check("a_hold_last", 32'(a_m_tlast), 32'(a_prev_l));
            end
            if (a_seen_last && !a_m_tvalid) a_gap++;
            if (a_m_tvalid && a_m_tready) begin
                if (exp_a.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_extra_byte: got %02h, required no byte", a_m_tdata);
                end else begin
                    ea = exp_a.pop_front();
                    check("a_byte{last,data}", 32'({a_m_tlast, a_m_tdata}), 32'({ea.last, ea.d}));
                end
                if (a_gap_en && a_seen_last) check("a_idle_gap", a_gap, 1);
                a_seen_last = a_m_tlast;
                a_gap = 0;
            end
            a_prev_stall = a_m_tvalid && !a_m_tready;
            a_prev_d     = a_m_tdata;
            a_prev_l     = a_m_tlast;
        end
    end

    // Monitor B: pops on every transfer, checks s_tready low during pad.
    always @(negedge clk) begin
        if (!rst && b_m_tvalid && b_m_tready) begin
            if (exp_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_extra_byte: got %02h, required no byte", b_m_tdata);
            end else begin
                eb = exp_b.pop_front();
                check("b_byte{last,data}", 32'({b_m_tlast, b_m_tdata}), 32'({eb.last, eb.d}));
                if (eb.pad) check("b_pad_s_tready", 32'(b_s_tready), 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        hb_def = '{8'hE8, 8'h6A, 8'h64, 8'hE7, 8'hE8, 8'h29,
                   8'hE8, 8'h6A, 8'h64, 8'hE7, 8'hE8, 8'h30, 8'h00, 8'h80};
        hb_new = '{8'hE8, 8'h6A, 8'h64, 8'hE7, 8'hE8, 8'h29,
                   8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h80};
        a_hdr.mac_destination = 48'he86a64e7e829;
        a_hdr.mac_source      = 48'he86a64e7e830;
        a_hdr.eth_type_length = 16'h0080;
        b_hdr = a_hdr;
        rst = 1'b1;
        a_s_tvalid = 1'b0; b_s_tvalid = 1'b0;
        a_s_tdata = 8'h00; b_s_tdata = 8'h00;
        b_m_tready = 1'b1;

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        check("rst_m_tvalid", 32'(a_m_tvalid), 0);
        check("rst_m_tlast", 32'(a_m_tlast), 0);
        check("rst_m_tdata", 32'(a_m_tdata), 0);
        check("rst_s_tready", 32'(a_s_tready), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_frame_count", 32'(a_fc), 0);
        check("rst_b_frame_count", 32'(b_fc), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: plain frame
        expect_frame(0, hb_def, 8'h00, 128, 46);
        send_payload(0, 8'h00, 128, -1, 1'b0);
        wait_drain(0);
        check("t1_frame_count", 32'(a_fc), 1);
        check("t1_busy_after", 32'(a_busy), 0);

        // 2: toggling m_tready plus a 3-cycle upstream gap
        rdy_mode = 1;
        expect_frame(0, hb_def, 8'h00, 128, 46);
        send_payload(0, 8'h00, 128, int'($urandom_range(20, 100)), 1'b0);
        wait_drain(0);
        rdy_mode = 0;
        @(posedge clk); #1;
        check("t2_frame_count", 32'(a_fc), 2);

        // 3: short payload with zero pad
        expect_frame(1, hb_def, 8'hA0, 10, 46);
        send_payload(1, 8'hA0, 10, -1, 1'b0);
        wait_drain(1);
        check("t3_frame_count", 32'(b_fc), 1);

        // 4: reset at payload byte 50
        expect_frame(0, hb_def, 8'h00, 128, 46);
        send_payload(0, 8'h00, 50, -1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t4_m_tvalid", 32'(a_m_tvalid), 0);
        check("t4_busy", 32'(a_busy), 0);
        check("t4_frame_count", 32'(a_fc), 0);
        rst = 1'b0;
        exp_a.delete();
        @(posedge clk); #1;
        expect_frame(0, hb_def, 8'h00, 128, 46);
        send_payload(0, 8'h00, 128, -1, 1'b0);
        wait_drain(0);
        check("t4_frame_count_after", 32'(a_fc), 1);

        // 5: header change during header byte 3 of frame 1
        expect_frame(0, hb_def, 8'h10, 128, 46);
        fork
            send_payload(0, 8'h10, 128, -1, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1;
                a_hdr.mac_source = 48'h112233445566;
            end
        join
        wait_drain(0);
        expect_frame(0, hb_new, 8'h20, 128, 46);
        send_payload(0, 8'h20, 128, -1, 1'b0);
        wait_drain(0);
        check("t5_frame_count", 32'(a_fc), 3);

        // 6: back-to-back frames, s_tvalid held high
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_a.delete();
        a_gap_en = 1'b1;
        expect_frame(0, hb_new, 8'h40, 128, 46);
        expect_frame(0, hb_new, 8'hC0, 128, 46);
        send_payload(0, 8'h40, 128, -1, 1'b1);
        send_payload(0, 8'hC0, 128, -1, 1'b0);
        wait_drain(0);
        check("t6_frame_count", 32'(a_fc), 2);

        check("a_queue_empty", exp_a.size(), 0);
        check("b_queue_empty", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
